// File: rtl/bht_ctrl.sv
// bht_ctrl: branch-direction predictor with 2-bit saturating counters and
// an ordered queue of in-flight predictions retired against EX outcomes.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   if_valid_i, if_is_branch_i   IF instruction qualifiers
//   if_pc_i, if_target_i         IF address and computed branch target
//   pred_taken_o, pred_pc_o      prediction and next fetch PC
//   if_stall_o                   IF hold (init sweep or queue full)
//   ex_valid_i, ex_taken_i       EX resolution of the oldest branch
//   ex_target_i                  actual branch target
//   flush_o, redirect_pc_o       one-cycle squash and correct fetch PC
//   br_cnt_o, miss_cnt_o         saturating resolved / mispredict counts
//   bp_err_o                     sticky: resolve seen with queue empty
module bht_ctrl #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic        if_is_branch_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_target_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_pc_o,
    output logic        if_stall_o,
    input  logic        ex_valid_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic [15:0] br_cnt_o,
    output logic [15:0] miss_cnt_o,
    output logic        bp_err_o
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN = 1'b1;

    logic             state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [1:0]       ctr_q [ENTRIES];

    logic [IDX_W-1:0] qidx_q  [DEPTH];
    logic             qpred_q [DEPTH];
    logic [31:0]      qtgt_q  [DEPTH];
    logic [31:0]      qft_q   [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic        flush_q, flush_d;
    logic [31:0] redir_q, redir_d;
    logic [15:0] br_q, br_d, miss_q, miss_d;
    logic        err_q, err_d;

    logic             run, is_br, full, empty;
    logic             resolve, pop, push, mispredict;
    logic [IDX_W-1:0] lk_idx, h_idx;
    logic             h_pred;
    logic [31:0]      h_tgt, h_ft, fallthru;
    logic [1:0]       h_ctr, ctr_upd;

    assign run = (state_q == ST_RUN);
    assign lk_idx = if_pc_i[IDX_W+1:2];
    assign fallthru = if_pc_i + 32'd4;
    assign is_br = if_valid_i & if_is_branch_i;
    assign full = (cnt_q == FULL);
    assign empty = (cnt_q == '0);

    assign pred_taken_o = run & is_br & ctr_q[lk_idx][1];
    assign pred_pc_o = pred_taken_o ? if_target_i : fallthru;
    // Stall looks only at the registered occupancy, so a same-cycle
    // pop does not let a waiting branch in.
    assign if_stall_o = ~run | (full & is_br);

    assign h_idx = qidx_q[rd_q];
    assign h_pred = qpred_q[rd_q];
    assign h_tgt = qtgt_q[rd_q];
    assign h_ft = qft_q[rd_q];
    assign h_ctr = ctr_q[h_idx];

    assign resolve = run & ex_valid_i;
    assign pop = resolve & ~empty;
    assign mispredict = pop & ((ex_taken_i != h_pred) |
                        (ex_taken_i & h_pred & (ex_target_i != h_tgt)));
    assign push = is_br & ~if_stall_o & ~mispredict;

    always_comb begin
        ctr_upd = h_ctr;
        if (ex_taken_i) begin
            if (h_ctr != 2'b11) ctr_upd = h_ctr + 2'b01;
        end else begin
            if (h_ctr != 2'b00) ctr_upd = h_ctr - 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (!run) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = ST_RUN;
        end
        rd_d = rd_q + PTR_W'(pop);
        wr_d = wr_q + PTR_W'(push);
        cnt_d = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        // A mispredict squashes every younger prediction still queued.
        if (mispredict) begin
            rd_d = '0;
            wr_d = '0;
            cnt_d = '0;
        end
        flush_d = mispredict;
        redir_d = redir_q;
        if (mispredict) redir_d = ex_taken_i ? ex_target_i : h_ft;
        br_d = br_q;
        if (pop && br_q != 16'hFFFF) br_d = br_q + 16'd1;
        miss_d = miss_q;
        if (mispredict && miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
        err_d = err_q | (resolve & empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            redir_q <= '0;
            br_q    <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            redir_q <= redir_d;
            br_q    <= br_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    // Table has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (!run) ctr_q[sweep_q] <= 2'b00;
            else if (pop) ctr_q[h_idx] <= ctr_upd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            qidx_q[wr_q]  <= lk_idx;
            qpred_q[wr_q] <= pred_taken_o;
            qtgt_q[wr_q]  <= if_target_i;
            qft_q[wr_q]   <= fallthru;
        end
    end

    assign flush_o = flush_q;
    assign redirect_pc_o = redir_q;
    assign br_cnt_o = br_q;
    assign miss_cnt_o = miss_q;
    assign bp_err_o = err_q;
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: directed and random stimulus against a queue-based
// reference model; flushes are checked by a separate monitor.
module tb_bht_ctrl;
    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int ENT = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_valid_i = 1'b0;
    logic        if_is_branch_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic [31:0] if_target_i = '0;
    logic        ex_valid_i = 1'b0;
    logic        ex_taken_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        pred_taken_o, if_stall_o, flush_o, bp_err_o;
    logic [31:0] pred_pc_o, redirect_pc_o;
    logic [15:0] br_cnt_o, miss_cnt_o;

    bht_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_valid_i(if_valid_i), .if_is_branch_i(if_is_branch_i),
        .if_pc_i(if_pc_i), .if_target_i(if_target_i),
        .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
        .if_stall_o(if_stall_o),
        .ex_valid_i(ex_valid_i), .ex_taken_i(ex_taken_i),
        .ex_target_i(ex_target_i),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o),
        .bp_err_o(bp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          pred;
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;
    typedef struct {
        int          cyc;
        logic [31:0] rd;
    } fl_t;

    ent_t mq[$];
    fl_t  sb[$];
    int   ctr[ENT];
    int   m_init = 0;
    int   m_br = 0;
    int   m_miss = 0;
    bit   m_err = 1'b0;
    bit   m_known = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: a flush is legal only in the cycle the model scheduled it.
    always @(negedge clk) begin
        if (m_known) begin
            bit   exp_f;
            fl_t  e;
            exp_f = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("flush", {31'd0, flush_o}, {31'd0, exp_f});
            if (exp_f) begin
                e = sb.pop_front();
                chk("redirect_pc", redirect_pc_o, e.rd);
            end
        end
    end

    task automatic step(input logic v, input logic br,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic exv, input logic ext,
                        input logic [31:0] etg, input logic r);
        bit          run, e_pred, e_stall, misp;
        int          idx;
        logic [31:0] e_pc;
        ent_t        h;
        if_valid_i = v;
        if_is_branch_i = br;
        if_pc_i = pc;
        if_target_i = tgt;
        ex_valid_i = exv;
        ex_taken_i = ext;
        ex_target_i = etg;
        rst_i = r;
        #2;
        run = (m_init == 0);
        idx = int'(pc[IDX_W+1:2]);
        e_pred = run && v && br && (ctr[idx] >= 2);
        e_pc = e_pred ? tgt : pc + 32'd4;
        e_stall = !run || (mq.size() == DEPTH && v && br);
        if (m_known) begin
            chk("br_cnt", {16'd0, br_cnt_o}, m_br);
            chk("miss_cnt", {16'd0, miss_cnt_o}, m_miss);
            chk("bp_err", {31'd0, bp_err_o}, {31'd0, m_err});
            chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, e_pred});
            chk("pred_pc", pred_pc_o, e_pc);
            chk("if_stall", {31'd0, if_stall_o}, {31'd0, e_stall});
        end
        if (r) begin
            mq.delete();
            foreach (ctr[i]) ctr[i] = 0;
            m_init = ENT;
            m_br = 0;
            m_miss = 0;
            m_err = 1'b0;
        end else if (!run) begin
            m_init--;
        end else begin
            misp = 1'b0;
            if (exv) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h = mq.pop_front();
                    if (ext) begin
                        if (ctr[h.idx] < 3) ctr[h.idx]++;
                    end else begin
                        if (ctr[h.idx] > 0) ctr[h.idx]--;
                    end
                    if (m_br < 65535) m_br++;
                    misp = (ext != h.pred) || (ext && h.pred && etg != h.tgt);
                    if (misp) begin
                        if (m_miss < 65535) m_miss++;
                        sb.push_back('{cyc: cyc + 1, rd: ext ? etg : h.ft});
                    end
                end
            end
            if (v && br && !e_stall && !misp)
                mq.push_back('{idx: idx, pred: e_pred, tgt: tgt, ft: pc + 32'd4});
            if (misp) mq.delete();
        end
        @(posedge clk);
        #1;
        if (r) m_known = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic brn(input logic [31:0] pc, input logic [31:0] tgt);
        step(1, 1, pc, tgt, 0, 0, 32'h0, 0);
    endtask

    task automatic res(input logic ext, input logic [31:0] etg);
        step(0, 0, 32'h0, 32'h0, 1, ext, etg, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h0, 1);
        chk("redirect_rst", redirect_pc_o, 32'h0);
        repeat (ENT + 2) step(1, 1, 32'h40, 32'h80, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            res(1, 32'h80);
            idle();
        end
        repeat (2) idle();

        // training: three taken resolves on 0x40
        for (int i = 0; i < 2; i++) begin
            brn(32'h40, 32'h80);
            res(1, 32'h80);
            idle();
        end
        brn(32'h40, 32'h80);
        res(0, 32'h0);
        idle();
        brn(32'h40, 32'h80);
        res(1, 32'h80);
        idle();

        // fill the queue, then hold a fifth branch
        for (int i = 1; i <= DEPTH; i++) brn(32'h100 + 32'(i * 4), 32'h200);
        repeat (3) brn(32'h114, 32'h200);
        step(1, 1, 32'h114, 32'h200, 1, 0, 32'h0, 0);
        brn(32'h114, 32'h200);
        res(1, 32'h200);
        repeat (3) res(0, 32'h0);
        idle();

        // taken with a different target than predicted
        brn(32'h40, 32'h80);
        res(0, 32'h0);
        idle();
        brn(32'h40, 32'h80);
        res(1, 32'h90);
        idle();
        brn(32'h40, 32'h80);
        idle();

        // reset coinciding with a resolve
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 1);
        repeat (ENT + 2) brn(32'h40, 32'h80);

        for (int n = 0; n < 600; n++) begin
            logic        v, b, exv, ext, r;
            logic [31:0] pc, tgt, etg;
            v = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 9) < 6);
            pc = 32'h1000 + 32'($urandom_range(0, 7) * 4);
            tgt = $urandom() & 32'hFFFF_FFFC;
            if (mq.size() > 0) exv = ($urandom_range(0, 9) < 4);
            else exv = ($urandom_range(0, 99) < 3);
            ext = $urandom_range(0, 1) == 1;
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) etg = mq[0].tgt;
            else etg = $urandom() & 32'hFFFF_FFFC;
            r = ($urandom_range(0, 199) == 0);
            step(v, b, pc, tgt, exv, ext, etg, r);
        end
        repeat (3) idle();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
